// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches over a ready handshake,
// selects the next PC on retire, counts retired fetches and traps misaligned PCs.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCPlus4,
  input  logic [31:0] PCTarget,
  input  logic        PCSrc,
  input  logic        Jump,
  input  logic        instr_accept,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] PC,
  output logic [31:0] Instr,
  output logic        instr_valid,
  output logic [31:0] fetch_count,
  output logic        fault
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HOLD  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_instr_valid;
  logic [31:0] r_fetch_count;
  logic        r_fault;
  logic [31:0] w_next_pc;
  logic        w_retire;
  logic        w_misaligned;

  // Jump outranks a taken branch when both are asserted.
  always_comb begin
    if (Jump) begin
      w_next_pc = {PCPlus4[31:28], r_instr[25:0], 2'b00};
    end else if (PCSrc) begin
      w_next_pc = PCTarget;
    end else begin
      w_next_pc = PCPlus4;
    end
  end

  assign w_retire     = (r_state == S_HOLD) && instr_accept;
  assign w_misaligned = (w_next_pc[1:0] != 2'b00);

  // NOTE: every output of this block gets a default first so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    imem_req     = 1'b0;
    case (r_state)
      S_REQ: begin
        imem_req = 1'b1;
        if (imem_ready) w_next_state = S_HOLD;
      end
      S_HOLD: begin
        if (instr_accept) w_next_state = w_misaligned ? S_FAULT : S_REQ;
      end
      S_FAULT: w_next_state = S_FAULT;
      default: w_next_state = S_REQ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_REQ;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_fetch_count <= '0;
      r_fault       <= 1'b0;
    end else begin
      if (r_state == S_REQ && imem_ready) begin
        r_instr       <= imem_rdata;
        r_instr_valid <= 1'b1;
      end
      if (w_retire) begin
        r_fetch_count <= r_fetch_count + 32'd1;
        r_instr_valid <= 1'b0;
        if (w_misaligned) r_fault <= 1'b1;
        else              r_pc    <= w_next_pc;
      end
    end
  end

  assign imem_addr   = r_pc;
  assign PC          = r_pc;
  assign Instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign fetch_count = r_fetch_count;
  assign fault       = r_fault;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: inputs change and outputs are checked on
// the falling edge, state advances on the rising edge.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCPlus4;
  logic [31:0] PCTarget;
  logic        PCSrc;
  logic        Jump;
  logic        instr_accept;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] PC;
  logic [31:0] Instr;
  logic        instr_valid;
  logic [31:0] fetch_count;
  logic        fault;

  int n_checks = 0;
  int n_pass   = 0;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .PCPlus4     (PCPlus4),
    .PCTarget    (PCTarget),
    .PCSrc       (PCSrc),
    .Jump        (Jump),
    .instr_accept(instr_accept),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .PC          (PC),
    .Instr       (Instr),
    .instr_valid (instr_valid),
    .fetch_count (fetch_count),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; PCPlus4 = '0; PCTarget = '0; PCSrc = 1'b0; Jump = 1'b0;
    instr_accept = 1'b0; imem_ready = 1'b0; imem_rdata = '0;
    tick(); tick();

    // Reset values
    check("rst_pc",    PC,          32'h0);
    check("rst_instr", Instr,       32'h0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_count", fetch_count, 32'h0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_req",   {31'd0, imem_req}, 32'd1);

    // Zero-wait fetch, immediate accept
    reset = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h2008_0005;
    check("t1_addr", imem_addr, 32'h0);
    tick();
    check("t1_valid", {31'd0, instr_valid}, 32'd1);
    check("t1_instr", Instr, 32'h2008_0005);
    check("t1_req_hold", {31'd0, imem_req}, 32'd0);
    imem_ready = 1'b0; instr_accept = 1'b1; PCPlus4 = 32'h4;
    tick();
    instr_accept = 1'b0;
    check("t1_pc",    PC, 32'h4);
    check("t1_count", fetch_count, 32'd1);
    check("t1_req",   {31'd0, imem_req}, 32'd1);
    check("t1_addr2", imem_addr, 32'h4);
    check("t1_valid0", {31'd0, instr_valid}, 32'd0);

    // Three wait states with stray accepts
    instr_accept = 1'b1; PCPlus4 = 32'h8;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t2_req_%0d", i),   {31'd0, imem_req}, 32'd1);
      check($sformatf("t2_valid_%0d", i), {31'd0, instr_valid}, 32'd0);
      check($sformatf("t2_pc_%0d", i),    PC, 32'h4);
      check($sformatf("t2_cnt_%0d", i),   fetch_count, 32'd1);
    end
    instr_accept = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h8C09_0000;
    tick();
    imem_ready = 1'b0;
    check("t2_valid", {31'd0, instr_valid}, 32'd1);
    check("t2_instr", Instr, 32'h8C09_0000);

    // Taken branch
    instr_accept = 1'b1; PCSrc = 1'b1; PCTarget = 32'h40; PCPlus4 = 32'h8;
    tick();
    instr_accept = 1'b0; PCSrc = 1'b0;
    check("t3_pc_br", PC, 32'h40);
    check("t3_cnt",   fetch_count, 32'd2);

    // Jump beats branch
    imem_ready = 1'b1; imem_rdata = 32'h0800_0100;
    tick();
    imem_ready = 1'b0;
    check("t3_instr", Instr, 32'h0800_0100);
    instr_accept = 1'b1; Jump = 1'b1; PCSrc = 1'b1; PCPlus4 = 32'h44; PCTarget = 32'h80;
    tick();
    instr_accept = 1'b0; Jump = 1'b0; PCSrc = 1'b0;
    check("t3_pc_jmp", PC, 32'h400);
    check("t3_cnt2",   fetch_count, 32'd3);

    // Jump keeps PCPlus4[31:28]
    imem_ready = 1'b1; imem_rdata = 32'h0800_0010;
    tick();
    imem_ready = 1'b0;
    instr_accept = 1'b1; Jump = 1'b1; PCPlus4 = 32'h9000_0404;
    tick();
    instr_accept = 1'b0; Jump = 1'b0;
    check("t3_pc_jhi", PC, 32'h9000_0040);

    // Misaligned branch target traps
    imem_ready = 1'b1; imem_rdata = 32'h1000_0001;
    tick();
    imem_ready = 1'b0;
    instr_accept = 1'b1; PCSrc = 1'b1; PCTarget = 32'h42; PCPlus4 = 32'h9000_0044;
    tick();
    check("t4_fault", {31'd0, fault}, 32'd1);
    check("t4_pc",    PC, 32'h9000_0040);
    check("t4_req",   {31'd0, imem_req}, 32'd0);
    check("t4_valid", {31'd0, instr_valid}, 32'd0);
    imem_ready = 1'b1; PCSrc = 1'b0;
    tick(); tick();
    check("t4_fault_stk", {31'd0, fault}, 32'd1);
    check("t4_pc_stk",    PC, 32'h9000_0040);
    check("t4_req_stk",   {31'd0, imem_req}, 32'd0);
    check("t4_valid_stk", {31'd0, instr_valid}, 32'd0);
    instr_accept = 1'b0; imem_ready = 1'b0; reset = 1'b1;
    tick();
    check("t4_fault_clr", {31'd0, fault}, 32'd0);
    check("t4_pc_clr",    PC, 32'h0);

    // Reset in HOLD with coincident accept
    reset = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h2008_0005;
    tick();
    imem_ready = 1'b0;
    tick();
    instr_accept = 1'b1; PCPlus4 = 32'h4;
    tick();
    check("t5_pc_pre",  PC, 32'h4);
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    check("t5_valid_pre", {31'd0, instr_valid}, 32'd1);
    reset = 1'b1; PCPlus4 = 32'h8;
    tick();
    check("t5_pc",    PC, 32'h0);
    check("t5_count", fetch_count, 32'd0);
    check("t5_valid", {31'd0, instr_valid}, 32'd0);
    check("t5_req",   {31'd0, imem_req}, 32'd1);

    // Counter wrap from all-ones
    reset = 1'b0; instr_accept = 1'b0; imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    force dut.r_fetch_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_fetch_count;
    check("t5_preload", fetch_count, 32'hFFFF_FFFF);
    instr_accept = 1'b1; PCPlus4 = 32'h4;
    tick();
    instr_accept = 1'b0;
    check("t5_wrap", fetch_count, 32'h0);
    check("t5_pc_wrap", PC, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Instruction-fetch stage of the MIPS single-cycle core: holds the architectural PC, fetches the instruction word from instruction memory over a ready-handshake, and presents PC/Instr to the datapath. It sits directly upstream of the PC-adder/sign-extend datapath stage, consumes that stage's `PCPlus4` and `PCTarget` results, and selects the next PC when the current instruction is retired. It also counts retired fetches and traps misaligned next-PC values.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset (must be word-aligned)
- `clk`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `PCPlus4`  in  32  PC+4 from datapath adder (combinational from `PC`)
- `PCTarget`  in  32  branch target from datapath adder
- `PCSrc`  in  1  branch taken, selects `PCTarget`
- `Jump`  in  1  jump, selects pseudo-direct target
- `instr_accept`  in  1  downstream consumed current instruction
- `imem_ready`  in  1  memory returns data this cycle
- `imem_rdata`  in  32  instruction word from memory
- `imem_req`  out  1  fetch request
- `imem_addr`  out  32  fetch address (= `PC`)
- `PC`  out  32  current PC
- `Instr`  out  32  registered instruction word; `Instr[25:0]` feeds datapath
- `instr_valid`  out  1  `Instr` valid for current `PC`
- `fetch_count`  out  32  number of accepted instructions
- `fault`  out  1  sticky misaligned-PC trap

## Operation
- States: REQ, HOLD, FAULT. Reset state REQ.
- Reset values: `PC`=RESET_PC, `Instr`=0, `instr_valid`=0, `fetch_count`=0, `fault`=0, state REQ.
- REQ: `imem_req`=1, `imem_addr`=`PC`. On `imem_ready`=1: `Instr`<=`imem_rdata`, `instr_valid`<=1, go HOLD. Otherwise stay (unlimited wait states).
- HOLD: `imem_req`=0, `instr_valid`=1, `Instr` stable. `imem_ready` ignored. On `instr_accept`=1: compute next PC, `fetch_count`<=`fetch_count`+1 (mod 2^32, wraps to 0), `instr_valid`<=0.
  - Next PC priority: `Jump` → {`PCPlus4[31:28]`, `Instr[25:0]`, 2'b00}; else `PCSrc` → `PCTarget`; else `PCPlus4`.
  - If next PC[1:0]==0: `PC`<=next PC, go REQ.
  - Else: `PC` unchanged, `fault`<=1, go FAULT.
- FAULT: `imem_req`=0, `instr_valid`=0, all inputs ignored; exit only by reset.
- `instr_accept` while `instr_valid`=0 ignored (no count, no PC change).
- `Jump` and `PCSrc` both high: `Jump` wins.
- `PC` wraps naturally (32'hFFFF_FFFC + 4 → 0) when `PCPlus4` supplied that way; no special handling.

## Timing
- `imem_req`, `imem_addr` are combinational from state/`PC`; all other outputs registered.
- Fetch latency: `imem_ready` sampled in cycle N (REQ) → `instr_valid`=1 and `Instr` valid in cycle N+1.
- `PC` updates in cycle after `instr_accept` edge; new request issued that same cycle.
- Zero-wait memory + immediate accept: one instruction per 2 cycles.
- `PCPlus4`/`PCTarget`/`PCSrc`/`Jump` sampled only on the accepting edge; must be stable that cycle.
- Reset asserted in any state, including mid-wait or HOLD: on next edge all state returns to reset values; a coincident `imem_ready` or `instr_accept` is discarded.

## Test plan
- Reset, `imem_ready`=1 immediately, `imem_rdata`=32'h2008_0005, accept next cycle, `PCPlus4`=4 → `instr_valid` high 1 cycle after ready, `PC`=4, `fetch_count`=1, `imem_req` re-asserted.
- Memory holds `imem_ready`=0 for 3 cycles in REQ → `imem_req`=1, `instr_valid`=0 throughout; data captured on 4th cycle; `instr_accept` pulses during wait ignored.
- `PCSrc`=1, `PCTarget`=32'h0000_0040 on accept → `PC`=0x40; then `Jump`=1 and `PCSrc`=1 with `PCPlus4`=0x44, `Instr[25:0]`=26'h0000_100 → `PC`=0x0000_0400.
- `PCSrc`=1, `PCTarget`=32'h0000_0042 on accept → `fault`=1, `PC` stays, `imem_req`=0, `instr_valid`=0; further inputs ignored until reset clears `fault`.
- Reset asserted while in HOLD with `instr_accept`=1 → `PC`=RESET_PC, `fetch_count`=0, `instr_valid`=0 next cycle; preload `fetch_count`=32'hFFFF_FFFF then accept → wraps to 0.
